// File: rtl/dds_pkg.sv
// dds_pkg: shared constants and helpers for the multi-channel DDS phase accumulator
package dds_pkg;

   localparam logic CFG_SEL_FTW = 1'b0;
   localparam logic CFG_SEL_POW = 1'b1;

   // Floor of freq * 2^accum_w / clk_freq, for benches and driver software
   function automatic longint unsigned ftw_from_hz(
      input longint unsigned freq,
      input longint unsigned clk_freq,
      input int unsigned     accum_w
   );
      return (freq << accum_w) / clk_freq;
   endfunction

endpackage

// File: rtl/dds_accum_ch.sv
// dds_accum_ch: one channel slice, accumulator (stage 1) and offset/truncate register (stage 2)
module dds_accum_ch #(
   parameter int ACCUM_W = 32,
   parameter int PHASE_W = 12
) (
   input  logic               clk_in,
   input  logic               rstn_in,
   input  logic               en_in,
   input  logic               clr_in,
   input  logic               v1_in,
   input  logic [ACCUM_W-1:0] ftw_in,
   input  logic [ACCUM_W-1:0] pow_in,
   output logic [PHASE_W-1:0] phase_out,
   output logic               wrap_out
);

   logic [ACCUM_W-1:0] acc;
   logic               carry;

   // Stage 1: clear beats accumulate; the carry out of the wide add marks a wrap
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in)
         {carry, acc} <= '0;
      else if (clr_in)
         {carry, acc} <= '0;
      else if (en_in)
         {carry, acc} <= {1'b0, acc} + {1'b0, ftw_in};

   // Stage 2: add the phase offset, keep the top PHASE_W bits, qualify the wrap with stage-1 valid
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) begin
         phase_out <= '0;
         wrap_out  <= 1'b0;
      end else begin
         phase_out <= PHASE_W'((acc + pow_in) >> (ACCUM_W - PHASE_W));
         wrap_out  <= carry & v1_in;
      end

endmodule

// File: rtl/dds_phase_accum_mc.sv
// dds_phase_accum_mc: multi-channel DDS phase accumulator with shadowed FTW/POW and coherent update
module dds_phase_accum_mc
   import dds_pkg::*;
#(
   parameter  int NUM_CH  = 4,
   parameter  int ACCUM_W = 32,
   parameter  int PHASE_W = 12,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                      clk_in,
   input  logic                      rstn_in,
   input  logic                      en_in,
   input  logic                      cfg_valid_in,
   output logic                      cfg_ready_out,
   input  logic [CH_W-1:0]           cfg_ch_in,
   input  logic                      cfg_sel_in,
   input  logic [ACCUM_W-1:0]        cfg_data_in,
   input  logic                      update_in,
   input  logic [NUM_CH-1:0]         phase_clr_in,
   output logic [NUM_CH*PHASE_W-1:0] phase_out,
   output logic [NUM_CH-1:0]         wrap_out,
   output logic                      phase_valid_out
);

   if (NUM_CH < 1 || NUM_CH > 16 || PHASE_W > ACCUM_W || PHASE_W < 1)
      $error("dds_phase_accum_mc: illegal parameter combination");

   logic [ACCUM_W-1:0] ftw_sh  [NUM_CH];
   logic [ACCUM_W-1:0] pow_sh  [NUM_CH];
   logic [ACCUM_W-1:0] ftw_act [NUM_CH];
   logic [ACCUM_W-1:0] pow_act [NUM_CH];
   logic               v1;
   logic               cfg_wr;

   assign cfg_wr = cfg_valid_in & cfg_ready_out;

   // Config port opens on the first edge after reset release and stays open
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in)
         cfg_ready_out <= 1'b0;
      else
         cfg_ready_out <= 1'b1;

   // Shadow writes: an out-of-range channel matches no slot, so the write is silently dropped
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ftw_sh[c] <= '0;
            pow_sh[c] <= '0;
         end
      end else if (cfg_wr) begin
         for (int c = 0; c < NUM_CH; c++)
            if (cfg_ch_in == CH_W'(c)) begin
               if (cfg_sel_in == CFG_SEL_FTW) ftw_sh[c] <= cfg_data_in;
               if (cfg_sel_in == CFG_SEL_POW) pow_sh[c] <= cfg_data_in;
            end
      end

   // Coherent update: all channels take their pre-edge shadow values on the same edge
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ftw_act[c] <= '0;
            pow_act[c] <= '0;
         end
      end else if (update_in) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ftw_act[c] <= ftw_sh[c];
            pow_act[c] <= pow_sh[c];
         end
      end

   // Valid follows the enable through the two datapath stages
   always_ff @(posedge clk_in or negedge rstn_in)
      if (!rstn_in) begin
         v1              <= 1'b0;
         phase_valid_out <= 1'b0;
      end else begin
         v1              <= en_in;
         phase_valid_out <= v1;
      end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      dds_accum_ch #(
         .ACCUM_W (ACCUM_W),
         .PHASE_W (PHASE_W)
      ) u_ch (
         .clk_in    (clk_in),
         .rstn_in   (rstn_in),
         .en_in     (en_in),
         .clr_in    (phase_clr_in[g]),
         .v1_in     (v1),
         .ftw_in    (ftw_act[g]),
         .pow_in    (pow_act[g]),
         .phase_out (phase_out[g*PHASE_W +: PHASE_W]),
         .wrap_out  (wrap_out[g])
      );
   end

endmodule

// File: doc/dds_phase_accum_mc.md
Name: dds_phase_accum_mc

Overview:
- Multi-channel, parametrised DDS phase accumulator; next generation of the single-channel 24-bit accumulator.
- Adds per-channel frequency tuning words (FTW) and phase offset words (POW) written over a valid/ready config port.
- Shadow-to-active update is coherent across all channels. Per-channel phase clear, wrap flags and a registered offset stage are included.
- Sits between the control/register interface and the phase-to-amplitude LUT; one phase word per channel per clock.

Parameters:
- NUM_CH, 4, number of independent channels (1..16)
- ACCUM_W, 32, accumulator width in bits
- PHASE_W, 12, truncated phase output width (PHASE_W <= ACCUM_W)
- CH_W, $clog2(NUM_CH) min 1, channel index width (derived localparam, not overridable)

Ports:
- clk_in  input  1  system clock
- rstn_in  input  1  asynchronous, active-low reset
- en_in  input  1  global accumulate enable
- cfg_valid_in  input  1  config write request
- cfg_ready_out  output  1  config port can accept a write
- cfg_ch_in  input  CH_W  target channel
- cfg_sel_in  input  1  0 = FTW shadow, 1 = POW shadow
- cfg_data_in  input  ACCUM_W  write data
- update_in  input  1  copy all shadow regs to active regs
- phase_clr_in  input  NUM_CH  per-channel accumulator clear mask
- phase_out  output  NUM_CH*PHASE_W  channel c at [c*PHASE_W +: PHASE_W]
- wrap_out  output  NUM_CH  per-channel accumulator overflow, aligned with phase_out
- phase_valid_out  output  1  phase_out is valid this cycle

Behaviour:
- Reset (asynchronous, rstn_in low): all shadow/active FTW/POW, accumulators, phase_out, wrap_out, phase_valid_out = 0. cfg_ready_out = 0.
- cfg_ready_out goes to 1 on the first clk_in edge after reset release and stays 1.
- Config write occurs when cfg_valid_in && cfg_ready_out at a clock edge.
  - Only the addressed shadow register changes.
  - cfg_ch_in >= NUM_CH: write is accepted and dropped; no register changes.
- update_in high at an edge: all active FTW/POW take the shadow values held *before* that edge. A write in the same cycle lands in shadow only and needs a later update. The new FTW is first used in the next accumulation.
- Stage 1 (accumulator), per channel c, at each edge, priority order:
  - phase_clr_in[c] = 1: acc[c] <= 0, carry[c] <= 0.
  - else en_in = 1: {carry[c], acc[c]} <= acc[c] + ftw_active[c], computed at ACCUM_W+1 bits; wrap modulo 2^ACCUM_W.
  - else: acc[c] and carry[c] hold.
- Stage 2 (output register), per channel c:
  - sum = acc[c] + pow_active[c] mod 2^ACCUM_W.
  - phase_out[c] <= sum[ACCUM_W-1 -: PHASE_W], truncated, no rounding.
  - wrap_out[c] <= carry[c] && stage-1 valid.
- phase_valid_out = en_in delayed by 2 registers. Latency from en_in/FTW/clear to phase_out is 2 cycles.
- POW changes affect phase_out 1 cycle after update, with no accumulator disturbance.
- Clear with en_in = 0 still clears. Clear and update in the same cycle: both apply.
- FTW = 0 holds phase. FTW = 2^(ACCUM_W-1) toggles the MSB every cycle with wrap every 2nd cycle.
- Reset asserted mid-operation clears everything immediately. Shadow contents are not preserved.

Decomposition:
- Shared package dds_pkg holds:
  - constants CFG_SEL_FTW = 1'b0 and CFG_SEL_POW = 1'b1;
  - helper function ftw_from_hz(freq, clk_freq, accum_w) for benches/software (integer, floor).
- One sub-module is natural: dds_accum_ch, a single-channel stage-1/stage-2 slice instantiated NUM_CH times by generate. The top holds the config port, shadow/active registers and valid pipeline.

Test Plan:
- Reset then write FTW ch0 = 0x1000_0000, update, en_in = 1 -> ch0 phase_out (PHASE_W = 12) = 0x100, 0x200, ... starting 2 cycles after en_in. wrap_out[0] pulses every 16th valid cycle. phase_valid_out rises exactly 2 cycles after en_in.
- Write FTW ch1 = 0x0100_0000 with no update -> ch1 stays 0. Pulse update_in -> ch1 advances by 0x010 per cycle. Write + update in the same cycle -> old shadow applied.
- Running ch2 at FTW 0x0800_0000, write POW ch2 = 0x8000_0000 and update -> ch2 phase_out jumps by 0x800 one cycle after update; accumulator progression unchanged.
- phase_clr_in = 4'b0101 for one cycle while all channels run -> ch0 and ch2 restart from the POW value 2 cycles later; ch1 and ch3 are uninterrupted.
- en_in low for 5 cycles -> phase_out holds the last value and phase_valid_out is low; resume continues from the held phase with no skipped step.
- cfg_ch_in = NUM_CH (invalid) write -> no channel changes. Assert rstn_in low mid-run -> all outputs 0 immediately; cfg_ready_out = 0 until the first edge after release.
